// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  alu_arbiter_pkg
//  Shared ALU/arbiter constants and the arbiter state encoding.
//  Revision: 1.0
// ============================================================================
package alu_arbiter_pkg;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_OP_WIDTH = 4;
    localparam int OP_COUNT     = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

endpackage : alu_arbiter_pkg
`default_nettype wire

// File: rtl/alu_arbiter_rr_grant2.sv
`default_nettype none
// ============================================================================
//  rr_grant2
//  Combinational two-input round-robin picker; prio breaks ties.
//  Revision: 1.0
// ============================================================================
module rr_grant2
    import alu_arbiter_pkg::*;
(
    input  logic [1:0] reqValid,
    input  logic       prio,
    output logic       grantIdx,
    output logic       grantValid
);

    always_comb begin
        grantValid = |reqValid;
        grantIdx   = (reqValid == 2'b11) ? prio : reqValid[1];
    end

endmodule : rr_grant2
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  alu_arbiter
//  Round-robin sharing of one combinational ALU between two requesters.
//  Revision: 1.0
// ============================================================================
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int OP_WIDTH = DEF_OP_WIDTH,
    parameter int OP_COUNT = alu_arbiter_pkg::OP_COUNT
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic [1:0]          reqValid,
    output logic [1:0]          reqReady,
    input  logic [WIDTH-1:0]    reqA0,
    input  logic [WIDTH-1:0]    reqB0,
    input  logic [WIDTH-1:0]    reqA1,
    input  logic [WIDTH-1:0]    reqB1,
    input  logic [OP_WIDTH-1:0] reqOp0,
    input  logic [OP_WIDTH-1:0] reqOp1,
    output logic [1:0]          respValid,
    input  logic [1:0]          respReady,
    output logic [WIDTH-1:0]    respResult,
    output logic                respZero,
    output logic                respOverflow,
    output logic                respError,
    output logic [WIDTH-1:0]    aluA,
    output logic [WIDTH-1:0]    aluB,
    output logic [OP_WIDTH-1:0] aluOp,
    input  logic [WIDTH-1:0]    aluResult,
    input  logic                aluZero,
    input  logic                aluOverflow
);

    state_e              state_q, state_d;
    logic                gnt_q, gnt_d;
    logic                prio_q, prio_d;
    logic [WIDTH-1:0]    aluA_q, aluA_d;
    logic [WIDTH-1:0]    aluB_q, aluB_d;
    logic [OP_WIDTH-1:0] aluOp_q, aluOp_d;
    logic [WIDTH-1:0]    result_q, result_d;
    logic                zero_q, zero_d;
    logic                ovf_q, ovf_d;
    logic                err_q, err_d;

    logic                w_gntIdx;
    logic                w_gntValid;
    logic [WIDTH-1:0]    w_selA;
    logic [WIDTH-1:0]    w_selB;
    logic [OP_WIDTH-1:0] w_selOp;
    logic                w_opLegal;

    rr_grant2 u_rr_grant2 (
        .reqValid   (reqValid),
        .prio       (prio_q),
        .grantIdx   (w_gntIdx),
        .grantValid (w_gntValid)
    );

    assign w_selA    = w_gntIdx ? reqA1  : reqA0;
    assign w_selB    = w_gntIdx ? reqB1  : reqB0;
    assign w_selOp   = w_gntIdx ? reqOp1 : reqOp0;
    assign w_opLegal = (32'(w_selOp) < 32'(OP_COUNT));

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        prio_d    = prio_q;
        aluA_d    = aluA_q;
        aluB_d    = aluB_q;
        aluOp_d   = aluOp_q;
        result_d  = result_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        err_d     = err_q;
        reqReady  = 2'b00;
        respValid = 2'b00;

        case (state_q)
            ST_IDLE: begin
                if (w_gntValid) begin
                    reqReady[w_gntIdx] = 1'b1;
                    gnt_d  = w_gntIdx;
                    prio_d = ~w_gntIdx;
                    // Illegal opcodes skip the ALU entirely so its buses stay quiet.
                    if (w_opLegal) begin
                        aluA_d  = w_selA;
                        aluB_d  = w_selB;
                        aluOp_d = w_selOp;
                        state_d = ST_ISSUE;
                    end else begin
                        result_d = '0;
                        zero_d   = 1'b0;
                        ovf_d    = 1'b0;
                        err_d    = 1'b1;
                        state_d  = ST_RESP;
                    end
                end
            end
            ST_ISSUE: begin
                result_d = aluResult;
                zero_d   = aluZero;
                ovf_d    = aluOverflow;
                err_d    = 1'b0;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                respValid[gnt_q] = 1'b1;
                if (respReady[gnt_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q  <= ST_IDLE;
            gnt_q    <= 1'b0;
            prio_q   <= 1'b0;
            aluA_q   <= '0;
            aluB_q   <= '0;
            aluOp_q  <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            prio_q   <= prio_d;
            aluA_q   <= aluA_d;
            aluB_q   <= aluB_d;
            aluOp_q  <= aluOp_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    assign aluA         = aluA_q;
    assign aluB         = aluB_q;
    assign aluOp        = aluOp_q;
    assign respResult   = result_q;
    assign respZero     = zero_q;
    assign respOverflow = ovf_q;
    assign respError    = err_q;

endmodule : alu_arbiter
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  tb_alu_arbiter
//  Directed and randomized checks of alu_arbiter against an adder stub ALU.
//  Revision: 1.0
// ============================================================================
module tb_alu_arbiter;

    localparam longint MAX_S = 64'sd2147483647;
    localparam longint MIN_S = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        resetN;
    logic [1:0]  reqValid, reqReady, respValid, respReady;
    logic [31:0] reqA0, reqB0, reqA1, reqB1;
    logic [3:0]  reqOp0, reqOp1;
    logic [31:0] respResult;
    logic        respZero, respOverflow, respError;
    logic [31:0] aluA, aluB, aluResult;
    logic [3:0]  aluOp;
    logic        aluZero, aluOverflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Stub ALU: every opcode adds.
    assign aluResult   = aluA + aluB;
    assign aluZero     = (aluResult == 32'd0);
    assign aluOverflow = (aluA[31] == aluB[31]) && (aluResult[31] != aluA[31]);

    alu_arbiter dut (
        .clk          (clk),
        .resetN       (resetN),
        .reqValid     (reqValid),
        .reqReady     (reqReady),
        .reqA0        (reqA0),
        .reqB0        (reqB0),
        .reqA1        (reqA1),
        .reqB1        (reqB1),
        .reqOp0       (reqOp0),
        .reqOp1       (reqOp1),
        .respValid    (respValid),
        .respReady    (respReady),
        .respResult   (respResult),
        .respZero     (respZero),
        .respOverflow (respOverflow),
        .respError    (respError),
        .aluA         (aluA),
        .aluB         (aluB),
        .aluOp        (aluOp),
        .aluResult    (aluResult),
        .aluZero      (aluZero),
        .aluOverflow  (aluOverflow)
    );

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic do_reset();
        resetN    = 1'b0;
        reqValid  = 2'b00;
        respReady = 2'b00;
        reqA0 = '0; reqB0 = '0; reqA1 = '0; reqB1 = '0;
        reqOp0 = '0; reqOp1 = '0;
        repeat (2) @(posedge clk);
        #1 resetN = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (respValid !== 2'b00) begin errors++; $display("FAIL reset_respValid: got %b want 00", respValid); end
        checks++; if (respResult !== 32'd0) begin errors++; $display("FAIL reset_respResult: got %h want 0", respResult); end
        checks++; if ({respZero, respOverflow, respError} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {respZero, respOverflow, respError}); end
        checks++; if (aluA !== 32'd0 || aluB !== 32'd0) begin errors++; $display("FAIL reset_aluAB: got %h/%h want 0/0", aluA, aluB); end
        checks++; if (aluOp !== 4'd0) begin errors++; $display("FAIL reset_aluOp: got %h want 0", aluOp); end
        checks++; if (reqReady !== 2'b00) begin errors++; $display("FAIL reset_reqReady: got %b want 00", reqReady); end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        reqValid = 2'b01; reqA0 = 32'd2; reqB0 = 32'd4; reqOp0 = 4'd1; respReady = 2'b01;
        #1;
        checks++; if (reqReady !== 2'b01) begin errors++; $display("FAIL single_reqReady: got %b want 01", reqReady); end
        @(posedge clk); #1;
        reqValid = 2'b00;
        #1;
        checks++; if (aluA !== 32'd2 || aluB !== 32'd4 || aluOp !== 4'd1) begin errors++; $display("FAIL single_aluBus: got %h/%h/%h want 2/4/1", aluA, aluB, aluOp); end
        checks++; if (respValid !== 2'b00 || reqReady !== 2'b00) begin errors++; $display("FAIL single_issueQuiet: got valid=%b ready=%b want 00/00", respValid, reqReady); end
        @(posedge clk); #1;
        checks++; if (respValid !== 2'b01) begin errors++; $display("FAIL single_respValid: got %b want 01", respValid); end
        checks++; if (respResult !== 32'd6) begin errors++; $display("FAIL single_result: got %h want 6", respResult); end
        checks++; if ({respZero, respOverflow, respError} !== 3'b000) begin errors++; $display("FAIL single_flags: got %b want 000", {respZero, respOverflow, respError}); end
        @(posedge clk); #1;
        checks++; if (respValid !== 2'b00) begin errors++; $display("FAIL single_respDone: got %b want 00", respValid); end
    endtask

    task automatic test_contention();
        logic [31:0] a0, b0, expRes;
        logic [1:0]  expOh;
        bit          g;
        do_reset();
        a0 = $urandom; b0 = $urandom;
        reqValid = 2'b11; respReady = 2'b11;
        reqA0 = a0; reqB0 = b0; reqOp0 = 4'd0;
        reqA1 = 32'd7; reqB1 = -32'sd7; reqOp1 = 4'd2;
        g = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expOh  = g ? 2'b10 : 2'b01;
            expRes = g ? 32'd0 : a0 + b0;
            #1;
            checks++; if (reqReady !== expOh) begin errors++; $display("FAIL contention_grant%0d: got %b want %b", i, reqReady, expOh); end
            @(posedge clk); #1;
            @(posedge clk); #1;
            checks++; if (respValid !== expOh) begin errors++; $display("FAIL contention_respValid%0d: got %b want %b", i, respValid, expOh); end
            checks++; if (respResult !== expRes || respZero !== (expRes == 32'd0)) begin
                errors++; $display("FAIL contention_result%0d: got %h z=%b want %h z=%b", i, respResult, respZero, expRes, expRes == 32'd0);
            end
            @(posedge clk); #1;
            g = ~g;
        end
        reqValid = 2'b00;
    endtask

    task automatic test_overflow_backpressure();
        do_reset();
        reqValid = 2'b01; reqA0 = 32'h7FFF_FFFF; reqB0 = 32'd1; reqOp0 = 4'd3;
        respReady = 2'b10;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            checks++; if (respValid !== 2'b01) begin errors++; $display("FAIL bp_respValid%0d: got %b want 01", k, respValid); end
            checks++; if (respResult !== 32'h8000_0000) begin errors++; $display("FAIL bp_result%0d: got %h want 80000000", k, respResult); end
            checks++; if ({respZero, respOverflow, respError} !== 3'b010) begin errors++; $display("FAIL bp_flags%0d: got %b want 010", k, {respZero, respOverflow, respError}); end
            checks++; if (reqReady !== 2'b00) begin errors++; $display("FAIL bp_reqReady%0d: got %b want 00", k, reqReady); end
            @(posedge clk); #1;
        end
        reqValid = 2'b00; respReady = 2'b01;
        #1;
        checks++; if (respValid !== 2'b01) begin errors++; $display("FAIL bp_stillValid: got %b want 01", respValid); end
        @(posedge clk); #1;
        checks++; if (respValid !== 2'b00) begin errors++; $display("FAIL bp_released: got %b want 00", respValid); end
    endtask

    task automatic test_invalid_op();
        do_reset();
        reqValid = 2'b01; reqA0 = 32'd10; reqB0 = 32'd20; reqOp0 = 4'd5; respReady = 2'b11;
        @(posedge clk); #1;
        reqValid = 2'b00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reqValid = 2'b10; reqA1 = $urandom; reqB1 = $urandom; reqOp1 = 4'd12;
        #1;
        checks++; if (reqReady !== 2'b10) begin errors++; $display("FAIL invalid_reqReady: got %b want 10", reqReady); end
        @(posedge clk); #1;
        reqValid = 2'b00;
        checks++; if (respValid !== 2'b10) begin errors++; $display("FAIL invalid_respValid: got %b want 10", respValid); end
        checks++; if (respError !== 1'b1 || respResult !== 32'd0) begin errors++; $display("FAIL invalid_errResult: got err=%b res=%h want 1/0", respError, respResult); end
        checks++; if (respZero !== 1'b0 || respOverflow !== 1'b0) begin errors++; $display("FAIL invalid_flags: got z=%b o=%b want 0/0", respZero, respOverflow); end
        checks++; if (aluOp !== 4'd5 || aluA !== 32'd10 || aluB !== 32'd20) begin errors++; $display("FAIL invalid_aluHeld: got %h/%h/%h want 10/20/5", aluA, aluB, aluOp); end
        @(posedge clk); #1;
        checks++; if (respValid !== 2'b00) begin errors++; $display("FAIL invalid_done: got %b want 00", respValid); end
    endtask

    task automatic test_reset_in_issue();
        do_reset();
        reqValid = 2'b01; reqA0 = 32'd3; reqB0 = 32'd9; reqOp0 = 4'd4; respReady = 2'b11;
        @(posedge clk); #1;
        reqValid = 2'b00;
        resetN   = 1'b0;
        @(posedge clk); #1;
        resetN = 1'b1;
        checks++; if (respValid !== 2'b00) begin errors++; $display("FAIL rstIssue_respValid: got %b want 00", respValid); end
        checks++; if (respResult !== 32'd0 || {respZero, respOverflow, respError} !== 3'b000) begin errors++; $display("FAIL rstIssue_resp: got %h %b want 0 000", respResult, {respZero, respOverflow, respError}); end
        checks++; if (aluA !== 32'd0 || aluB !== 32'd0 || aluOp !== 4'd0) begin errors++; $display("FAIL rstIssue_alu: got %h/%h/%h want 0/0/0", aluA, aluB, aluOp); end
        reqValid = 2'b11; reqA1 = 32'd1; reqB1 = 32'd1; reqOp1 = 4'd0;
        #1;
        checks++; if (reqReady !== 2'b01) begin errors++; $display("FAIL rstIssue_prio: got %b want 01", reqReady); end
        @(posedge clk); #1;
        reqValid = 2'b00;
        @(posedge clk); #1;
        checks++; if (respValid !== 2'b01 || respResult !== 32'd12) begin errors++; $display("FAIL rstIssue_after: got %b %h want 01 0000000c", respValid, respResult); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        bit          m_busy = 1'b0;
        int          m_wait = 0;
        bit          m_g = 1'b0;
        bit          m_prio = 1'b0;
        logic [31:0] m_res = '0, m_aA = '0, m_aB = '0;
        logic [3:0]  m_aOp = '0;
        bit          m_z = 1'b0, m_o = 1'b0, m_e = 1'b0;
        logic [1:0]  expRdy, expVld;
        logic [31:0] a, b;
        logic [3:0]  op;
        bit          g;
        longint      s;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            reqValid  = 2'($urandom_range(0, 3));
            reqA0 = rnd_operand(); reqB0 = rnd_operand();
            reqA1 = rnd_operand(); reqB1 = rnd_operand();
            reqOp0 = 4'($urandom_range(0, 15));
            reqOp1 = 4'($urandom_range(0, 15));
            respReady = 2'($urandom_range(0, 3));
            #1;
            expVld = (m_busy && m_wait == 0) ? (m_g ? 2'b10 : 2'b01) : 2'b00;
            checks++; if (respValid !== expVld) begin errors++; $display("FAIL rand_respValid@%0d: got %b want %b", cyc, respValid, expVld); end
            if (expVld != 2'b00) begin
                checks++; if ({respResult, respZero, respOverflow, respError} !== {m_res, m_z, m_o, m_e}) begin
                    errors++; $display("FAIL rand_resp@%0d: got %h %b%b%b want %h %b%b%b", cyc, respResult, respZero, respOverflow, respError, m_res, m_z, m_o, m_e);
                end
            end
            checks++; if (aluA !== m_aA || aluB !== m_aB || aluOp !== m_aOp) begin
                errors++; $display("FAIL rand_alu@%0d: got %h/%h/%h want %h/%h/%h", cyc, aluA, aluB, aluOp, m_aA, m_aB, m_aOp);
            end
            g = 1'b0; expRdy = 2'b00;
            if (!m_busy && reqValid != 2'b00) begin
                g = (reqValid == 2'b11) ? m_prio : reqValid[1];
                expRdy = g ? 2'b10 : 2'b01;
            end
            checks++; if (reqReady !== expRdy) begin errors++; $display("FAIL rand_reqReady@%0d: got %b want %b", cyc, reqReady, expRdy); end
            if (!m_busy) begin
                if (reqValid != 2'b00) begin
                    m_busy = 1'b1; m_g = g; m_prio = !g;
                    a  = g ? reqA1  : reqA0;
                    b  = g ? reqB1  : reqB0;
                    op = g ? reqOp1 : reqOp0;
                    if (op < 4'd10) begin
                        m_aA = a; m_aB = b; m_aOp = op;
                        s = longint'($signed(a)) + longint'($signed(b));
                        m_res = s[31:0];
                        m_z = (m_res == 32'd0);
                        m_o = (s > MAX_S) || (s < MIN_S);
                        m_e = 1'b0;
                        m_wait = 1;
                    end else begin
                        m_res = '0; m_z = 1'b0; m_o = 1'b0; m_e = 1'b1;
                        m_wait = 0;
                    end
                end
            end else if (m_wait > 0) begin
                m_wait--;
            end else if (respReady[m_g]) begin
                m_busy = 1'b0;
            end
            @(posedge clk); #1;
        end
        reqValid = 2'b00;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_overflow_backpressure();
        test_invalid_op();
        test_reset_in_issue();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_alu_arbiter
`default_nettype wire
